// File: rtl/heard_indication_tx.sv
// Queues say(meth, v) requests in a small FIFO and replays them as heard(meth, v) calls,
// optionally spacing consecutive heard transfers by GAP idle cycles.
module heard_indication_tx #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned GAP   = 0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        request_say_ena_i,
   input  logic [31:0] request_say_meth_i,
   input  logic [31:0] request_say_v_i,
   output logic        request_say_rdy_o,
   output logic        indication_heard_ena_o,
   output logic [31:0] indication_heard_meth_o,
   output logic [31:0] indication_heard_v_o,
   input  logic        indication_heard_rdy_i,
   output logic [31:0] sent_count,
   output logic        busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
   localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   logic [63:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic [1:0]    state_q, state_d;
   logic [7:0]    gap_q, gap_d;
   logic [31:0]   sent_q, sent_d;
   logic          started_q;
   logic          push, pop;

   // started_q keeps RDY low during reset and until the first clock edge after release.
   assign request_say_rdy_o       = started_q && (count_q < FULL);
   assign indication_heard_ena_o  = (state_q == SEND) && (count_q != '0);
   assign indication_heard_meth_o = mem_q[rd_ptr_q][63:32];
   assign indication_heard_v_o    = mem_q[rd_ptr_q][31:0];
   assign sent_count              = sent_q;
   assign busy                    = (count_q != '0) || (state_q == WAIT);

   assign push   = request_say_ena_i && request_say_rdy_o;
   assign pop    = indication_heard_ena_o && indication_heard_rdy_i;
   assign sent_d = pop ? sent_q + 32'd1 : sent_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: begin
            // Looking at count_d lets a push into an empty FIFO show up on ENA next cycle.
            if (count_d != '0) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (pop) begin
               if (GAP > 0) begin
                  state_d = WAIT;
                  gap_d   = GAP_LOAD;
               end else if (count_d == '0) begin
                  state_d = IDLE;
               end
            end else if (count_q == '0) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (gap_q == 8'd0) begin
               state_d = (count_d != '0) ? SEND : IDLE;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         gap_q     <= 8'd0;
         sent_q    <= 32'd0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         gap_q     <= gap_d;
         sent_q    <= sent_d;
         started_q <= 1'b1;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {request_say_meth_i, request_say_v_i};
      end
   end

endmodule

// File: tb/tb_heard_indication_tx.sv
// Drives two heard_indication_tx instances (GAP=0 and GAP=3, DEPTH=4) with one stimulus stream
// and checks both against a queue-based model every cycle, plus directed literal expectations.
module tb_heard_indication_tx;

   logic        CLK;
   logic        nRST;
   logic        req_ena;
   logic [31:0] req_meth;
   logic [31:0] req_v;
   logic        hrdy;
   logic        rdy   [2];
   logic        ena   [2];
   logic [31:0] hmeth [2];
   logic [31:0] hv    [2];
   logic [31:0] sent  [2];
   logic        bsy   [2];

   int checks;
   int errors;

   logic [63:0] mq [2][$];
   int          since [2];
   logic [31:0] msent [2];
   bit          mstart [2];

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      heard_indication_tx #(
         .DEPTH(4),
         .GAP  ((g == 0) ? 0 : 3)
      ) u_dut (
         .CLK                    (CLK),
         .nRST                   (nRST),
         .request_say_ena_i      (req_ena),
         .request_say_meth_i     (req_meth),
         .request_say_v_i        (req_v),
         .request_say_rdy_o      (rdy[g]),
         .indication_heard_ena_o (ena[g]),
         .indication_heard_meth_o(hmeth[g]),
         .indication_heard_v_o   (hv[g]),
         .indication_heard_rdy_i (hrdy),
         .sent_count             (sent[g]),
         .busy                   (bsy[g])
      );
   end

   always #5 CLK = ~CLK;

   function automatic int gapv(int i);
      return (i == 0) ? 0 : 3;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         since[i]  = 1000;
         msent[i]  = 32'd0;
         mstart[i] = 1'b0;
      end
   endtask

   // Apply the coming posedge to the model, then compare the DUTs at the following negedge.
   task automatic tick();
      for (int i = 0; i < 2; i++) begin
         bit m_rdy;
         bit m_ena;
         if (nRST) begin
            m_rdy = mstart[i] && (mq[i].size() < 4);
            m_ena = (mq[i].size() > 0) && (since[i] > gapv(i));
            if (m_ena && hrdy) begin
               void'(mq[i].pop_front());
               msent[i]++;
               since[i] = 1;
            end else if (since[i] < 1000) begin
               since[i]++;
            end
            if (req_ena && m_rdy) mq[i].push_back({req_meth, req_v});
            mstart[i] = 1'b1;
         end
      end
      if (!nRST) model_reset();
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
         bit e_ena;
         e_ena = (mq[i].size() > 0) && (since[i] > gapv(i));
         chk($sformatf("rdy%0d", i), rdy[i], mstart[i] && (mq[i].size() < 4));
         chk($sformatf("ena%0d", i), ena[i], e_ena);
         chk($sformatf("busy%0d", i), bsy[i], (mq[i].size() > 0) || (since[i] <= gapv(i)));
         chk($sformatf("sent%0d", i), sent[i], msent[i]);
         if (e_ena) chk($sformatf("data%0d", i), {hmeth[i], hv[i]}, mq[i][0]);
      end
   endtask

   task automatic push_one(logic [31:0] m, logic [31:0] v);
      req_ena  = 1'b1;
      req_meth = m;
      req_v    = v;
      tick();
      req_ena  = 1'b0;
   endtask

   task automatic drain();
      bit done;
      hrdy    = 1'b1;
      req_ena = 1'b0;
      done    = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         done = (mq[0].size() == 0) && (mq[1].size() == 0) && (since[1] > 3);
         if (!done) tick();
      end
      chk("drain_done", done, 1'b1);
   endtask

   initial begin
      int pops[$];
      CLK      = 1'b0;
      nRST     = 1'b0;
      req_ena  = 1'b0;
      req_meth = 32'd0;
      req_v    = 32'd0;
      hrdy     = 1'b0;
      checks   = 0;
      errors   = 0;
      model_reset();

      // Reset state
      tick();
      tick();
      chk("reset_rdy", rdy[0], 1'b0);
      chk("reset_ena", ena[0], 1'b0);
      chk("reset_busy", bsy[0], 1'b0);
      chk("reset_sent", sent[0], 32'd0);
      nRST = 1'b1;
      #1 chk("rdy_before_edge", rdy[0], 1'b0);
      tick();
      chk("rdy_after_edge", rdy[0], 1'b1);

      // Single push, next-cycle ENA, one pop
      hrdy = 1'b1;
      push_one(32'd1, 32'h55);
      chk("lat_ena", ena[0], 1'b1);
      chk("lat_data", {hmeth[0], hv[0]}, {32'd1, 32'h55});
      tick();
      chk("lat_sent", sent[0], 32'd1);
      chk("lat_ena_off", ena[0], 1'b0);
      drain();

      // Fill to DEPTH with receiver stalled, fifth push ignored, then back-to-back drain
      hrdy = 1'b0;
      for (int k = 0; k < 5; k++) push_one(32'd10 + 32'(k), 32'(k));
      chk("full_rdy", rdy[0], 1'b0);
      hrdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("b2b_ena_%0d", k), ena[0], 1'b1);
         chk($sformatf("b2b_meth_%0d", k), hmeth[0], 32'd10 + 32'(k));
         tick();
      end
      chk("b2b_empty", ena[0], 1'b0);
      drain();

      // Push and pop in the same cycle at occupancy 2
      hrdy = 1'b0;
      push_one(32'd20, 32'd0);
      push_one(32'd21, 32'd0);
      hrdy = 1'b1;
      push_one(32'd22, 32'd0);
      chk("pp_head", hmeth[0], 32'd21);
      tick();
      chk("pp_next", hmeth[0], 32'd22);
      drain();

      // GAP=3 spacing on instance 1
      hrdy = 1'b0;
      for (int k = 0; k < 3; k++) push_one(32'd30 + 32'(k), 32'd0);
      hrdy = 1'b1;
      for (int c = 0; c < 15; c++) begin
         if (ena[1]) pops.push_back(c);
         tick();
      end
      chk("gap_pops", pops.size(), 3);
      if (pops.size() == 3) begin
         chk("gap_first", pops[0], 0);
         chk("gap_step1", pops[1] - pops[0], 4);
         chk("gap_step2", pops[2] - pops[1], 4);
      end
      drain();

      // Asynchronous reset with entries queued and ENA high
      hrdy = 1'b0;
      for (int k = 0; k < 3; k++) push_one(32'd40 + 32'(k), 32'd0);
      chk("pre_rst_ena", ena[0], 1'b1);
      #2 nRST = 1'b0;
      #1;
      chk("async_ena0", ena[0], 1'b0);
      chk("async_ena1", ena[1], 1'b0);
      chk("async_sent", sent[0], 32'd0);
      chk("async_busy", bsy[0], 1'b0);
      tick();
      nRST = 1'b1;
      hrdy = 1'b1;
      tick();
      tick();
      chk("no_stale_ena", ena[0], 1'b0);
      chk("no_stale_sent", sent[0], 32'd0);

      // sent_count wrap
      hrdy = 1'b0;
      push_one(32'd50, 32'd5);
      force gen_dut[0].u_dut.sent_d = 32'hFFFF_FFFF;
      msent[0] = 32'hFFFF_FFFF;
      tick();
      chk("pre_wrap", sent[0], 32'hFFFF_FFFF);
      release gen_dut[0].u_dut.sent_d;
      hrdy = 1'b1;
      tick();
      chk("wrap", sent[0], 32'd0);
      drain();

      // Mixed traffic
      for (int i = 0; i < 40; i++) begin
         req_ena  = (i % 3) != 0;
         req_meth = 32'd100 + 32'(i);
         req_v    = 32'(i * 7);
         hrdy     = (i % 5) < 3;
         tick();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
